// File: rtl/shift_in_byte.sv
// Serial-to-parallel byte assembler with a one-deep output register and a held-frame stage.
// Optional even-parity frame checking is enabled by defining PARITY_CHECK_EN.
module shift_in_byte #(
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_in_bit,
  input  logic       io_in_valid,
  output logic       io_in_ready,
  output logic [7:0] io_out_bits,
  output logic       io_out_valid,
  input  logic       io_out_ready
`ifdef PARITY_CHECK_EN
  ,
  output logic       io_out_perr
`endif
);

`ifdef PARITY_CHECK_EN
  localparam int unsigned FrameLen = 9;
`else
  localparam int unsigned FrameLen = 8;
`endif
  localparam int unsigned CntW = 4;

  typedef enum logic [0:0] {StCollect, StHold} state_e;

  state_e              state_q, state_d;
  logic [FrameLen-1:0] shift_q, shift_d, shifted;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [7:0]          out_bits_q, out_bits_d;
  logic                out_valid_q, out_valid_d;
  logic                in_fire, out_fire;
`ifdef PARITY_CHECK_EN
  logic                perr_q, perr_d;
`endif

  // Data bits always precede the parity bit, so their position depends on shift direction.
  function automatic logic [7:0] frame_data(input logic [FrameLen-1:0] f);
    if (LSB_FIRST != 0) return f[7:0];
    else                return f[FrameLen-1 -: 8];
  endfunction

  assign in_fire  = io_in_valid && (state_q == StCollect);
  assign out_fire = out_valid_q && io_out_ready;
  assign shifted  = (LSB_FIRST != 0) ? {io_in_bit, shift_q[FrameLen-1:1]}
                                     : {shift_q[FrameLen-2:0], io_in_bit};

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    out_bits_d  = out_bits_q;
    out_valid_d = out_valid_q;
`ifdef PARITY_CHECK_EN
    perr_d      = perr_q;
`endif
    if (out_fire) out_valid_d = 1'b0;

    unique case (state_q)
      StCollect: begin
        if (in_fire) begin
          shift_d = shifted;
          if (cnt_q == CntW'(FrameLen - 1)) begin
            cnt_d = '0;
            if (!out_valid_q || out_fire) begin
              out_bits_d  = frame_data(shifted);
              out_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
              perr_d      = ^shifted;
`endif
            end else begin
              state_d = StHold;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHold: begin
        if (out_fire) begin
          out_bits_d  = frame_data(shift_q);
          out_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
          perr_d      = ^shift_q;
`endif
          state_d     = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StCollect;
      shift_q     <= '0;
      cnt_q       <= '0;
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      out_bits_q  <= out_bits_d;
      out_valid_q <= out_valid_d;
`ifdef PARITY_CHECK_EN
      perr_q      <= perr_d;
`endif
    end
  end

  // Depends only on the state register, never on io_out_ready.
  assign io_in_ready  = (state_q == StCollect);
  assign io_out_bits  = out_bits_q;
  assign io_out_valid = out_valid_q;
`ifdef PARITY_CHECK_EN
  assign io_out_perr  = perr_q;
`endif

endmodule

// File: tb/tb_shift_in_byte.sv
// Directed bench for shift_in_byte; an LSB-first and an MSB-first instance share the stimulus.
module tb_shift_in_byte;

`ifdef PARITY_CHECK_EN
  localparam int FrameLen = 9;
`else
  localparam int FrameLen = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       io_in_bit = 1'b0;
  logic       io_in_valid = 1'b0;
  logic       io_out_ready = 1'b0;
  logic       io_in_ready, m_in_ready;
  logic [7:0] io_out_bits, m_out_bits;
  logic       io_out_valid, m_out_valid;
`ifdef PARITY_CHECK_EN
  logic       io_out_perr, m_out_perr;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_in_byte #(.LSB_FIRST(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_bit    (io_in_bit),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_out_bits  (io_out_bits),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready)
`ifdef PARITY_CHECK_EN
    ,
    .io_out_perr  (io_out_perr)
`endif
  );

  shift_in_byte #(.LSB_FIRST(0)) dut_msb (
    .clk          (clk),
    .reset        (reset),
    .io_in_bit    (io_in_bit),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (m_in_ready),
    .io_out_bits  (m_out_bits),
    .io_out_valid (m_out_valid),
    .io_out_ready (io_out_ready)
`ifdef PARITY_CHECK_EN
    ,
    .io_out_perr  (m_out_perr)
`endif
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    io_in_valid = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    io_in_bit = b;
    io_in_valid = 1'b1;
    cycle();
    io_in_valid = 1'b0;
  endtask

  // Data sent bit 0 first, then the even-parity bit when frames carry one.
  task automatic send_frame(input logic [7:0] d);
    logic [8:0] fv;
    fv = {^d, d};
    for (int i = 0; i < FrameLen; i++) send_bit(fv[i]);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (io_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", io_out_valid);
    end
    checks++;
    if (io_out_bits !== 8'h00) begin
      errors++; $display("FAIL reset_bits: got %h want 00", io_out_bits);
    end
    checks++;
    if (io_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", io_in_ready);
    end
`ifdef PARITY_CHECK_EN
    checks++;
    if (io_out_perr !== 1'b0) begin
      errors++; $display("FAIL reset_perr: got %b want 0", io_out_perr);
    end
`endif
  endtask

  task automatic test_lsb_first();
    logic [8:0] fv;
    fv = {^8'hA5, 8'hA5};
    do_reset();
    io_out_ready = 1'b1;
    for (int i = 0; i < FrameLen - 1; i++) send_bit(fv[i]);
    checks++;
    if (io_out_valid !== 1'b0) begin
      errors++; $display("FAIL lsb_early_valid: got %b want 0", io_out_valid);
    end
    send_bit(fv[FrameLen-1]);
    checks++;
    if (io_out_valid !== 1'b1 || io_out_bits !== 8'hA5) begin
      errors++;
      $display("FAIL lsb_a5: got valid=%b bits=%h want valid=1 bits=a5", io_out_valid, io_out_bits);
    end
    checks++;
    if (m_out_bits !== 8'hA5) begin
      errors++; $display("FAIL msb_a5: got %h want a5", m_out_bits);
    end
    cycle();
    checks++;
    if (io_out_valid !== 1'b0) begin
      errors++; $display("FAIL lsb_consumed: got valid=%b want 0", io_out_valid);
    end
    io_out_ready = 1'b0;
  endtask

  task automatic test_msb_first();
    do_reset();
    io_out_ready = 1'b1;
    send_frame(8'h03);  // serial 1,1,0,0,0,0,0,0
    checks++;
    if (m_out_valid !== 1'b1 || m_out_bits !== 8'hC0) begin
      errors++;
      $display("FAIL msb_c0: got valid=%b bits=%h want valid=1 bits=c0", m_out_valid, m_out_bits);
    end
    checks++;
    if (io_out_bits !== 8'h03) begin
      errors++; $display("FAIL lsb_03: got %h want 03", io_out_bits);
    end
    cycle();
    io_out_ready = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    io_out_ready = 1'b0;
    send_frame(8'h11);
    checks++;
    if (io_out_valid !== 1'b1 || io_out_bits !== 8'h11 || io_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_first: got valid=%b bits=%h in_ready=%b want 1 11 1",
               io_out_valid, io_out_bits, io_in_ready);
    end
    send_frame(8'h22);
    checks++;
    if (io_in_ready !== 1'b0 || io_out_bits !== 8'h11) begin
      errors++;
      $display("FAIL hold_enter: got in_ready=%b bits=%h want 0 11", io_in_ready, io_out_bits);
    end
    // Bits offered while holding must be ignored.
    io_in_bit = 1'b1;
    io_in_valid = 1'b1;
    repeat (3) cycle();
    io_in_valid = 1'b0;
    checks++;
    if (io_out_bits !== 8'h11 || io_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_stable: got bits=%h valid=%b want 11 1", io_out_bits, io_out_valid);
    end
    io_out_ready = 1'b1;
    cycle();
    io_out_ready = 1'b0;
    checks++;
    if (io_out_bits !== 8'h22 || io_out_valid !== 1'b1 || io_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got bits=%h valid=%b in_ready=%b want 22 1 1",
               io_out_bits, io_out_valid, io_in_ready);
    end
    io_out_ready = 1'b1;
    cycle();
    io_out_ready = 1'b0;
    checks++;
    if (io_out_valid !== 1'b0) begin
      errors++; $display("FAIL hold_drain: got valid=%b want 0", io_out_valid);
    end
    send_frame(8'h5A);
    checks++;
    if (io_out_bits !== 8'h5A || io_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_next: got bits=%h valid=%b want 5a 1", io_out_bits, io_out_valid);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    io_out_ready = 1'b0;
    send_frame(8'h77);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    do_reset();
    checks++;
    if (io_out_valid !== 1'b0 || io_out_bits !== 8'h00 || io_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b bits=%h in_ready=%b want 0 00 1",
               io_out_valid, io_out_bits, io_in_ready);
    end
    send_frame(8'h3C);
    checks++;
    if (io_out_valid !== 1'b1 || io_out_bits !== 8'h3C) begin
      errors++;
      $display("FAIL after_reset_3c: got valid=%b bits=%h want 1 3c", io_out_valid, io_out_bits);
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    do_reset();
    io_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(i < 2);
    send_bit(1'b0);
    checks++;
    if (io_out_perr !== 1'b0 || io_out_bits !== 8'h03) begin
      errors++;
      $display("FAIL parity_good: got perr=%b bits=%h want 0 03", io_out_perr, io_out_bits);
    end
    for (int i = 0; i < 8; i++) send_bit(i < 2);
    send_bit(1'b1);
    checks++;
    if (io_out_perr !== 1'b1 || io_out_bits !== 8'h03 || io_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL parity_bad: got perr=%b bits=%h valid=%b want 1 03 1",
               io_out_perr, io_out_bits, io_out_valid);
    end
    cycle();
    io_out_ready = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    logic [8:0] fv;
    int drops, xfers;
    bytes = '{8'h12, 8'h34, 8'hAB, 8'hFF};
    drops = 0;
    xfers = 0;
    do_reset();
    io_out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      fv = {^bytes[b], bytes[b]};
      for (int i = 0; i < FrameLen; i++) begin
        io_in_valid = 1'b1;
        io_in_bit = fv[i];
        cycle();
        if (io_in_ready !== 1'b1) drops++;
        if (io_out_valid === 1'b1) begin
          xfers++;
          checks++;
          if (i != FrameLen - 1 || io_out_bits !== bytes[b]) begin
            errors++;
            $display("FAIL b2b_byte%0d: got bits=%h at bit %0d want %h at bit %0d",
                     b, io_out_bits, i, bytes[b], FrameLen - 1);
          end
        end
      end
    end
    io_in_valid = 1'b0;
    checks++;
    if (drops != 0) begin
      errors++; $display("FAIL b2b_in_ready: got %0d drops want 0", drops);
    end
    checks++;
    if (xfers != 4) begin
      errors++; $display("FAIL b2b_transfers: got %0d want 4 in %0d cycles", xfers, 4 * FrameLen);
    end
    cycle();
    io_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_hold();
    test_mid_reset();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_in_byte.md
SHIFT_IN_BYTE -- requirements
Module: shift_in_byte

Interface
REQ-001 Parameter LSB_FIRST, default 1; 1 = first accepted serial bit lands in io_out_bits[0], 0 = first bit lands in io_out_bits[7].
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 io_in_bit  input  1  serial data bit.
REQ-005 io_in_valid  input  1  io_in_bit is valid this cycle.
REQ-006 io_in_ready  output  1  block accepts a bit this cycle; a transfer occurs when io_in_valid and io_in_ready are both high.
REQ-007 io_out_bits  output  8  assembled byte; drives the downstream 8-bit register's D input.
REQ-008 io_out_valid  output  1  io_out_bits holds an undelivered byte.
REQ-009 io_out_ready  input  1  consumer takes the byte; a transfer occurs when io_out_valid and io_out_ready are both high.
REQ-010 io_out_perr  output  1  parity error flag paired with io_out_bits; this port exists only when PARITY_CHECK_EN is defined.

Function
REQ-011 The block SHALL contain a shift register, a bit counter, an 8-bit output register and an output-valid flag; states are COLLECT (counter < frame length) and HOLD (complete frame in the shift register, output register occupied).
REQ-012 In COLLECT, io_in_ready SHALL be 1; each input transfer shifts io_in_bit into position per LSB_FIRST and increments the counter.
REQ-013 On the transfer of the last bit of a frame, the assembled byte SHALL load into the output register when io_out_valid is 0 or an output transfer occurs in the same cycle; io_out_valid = 1 the next cycle (latency 1 cycle after the last bit); the counter returns to 0.
REQ-014 If the last bit arrives while io_out_valid = 1 and io_out_ready = 0, the block SHALL enter HOLD; io_in_ready = 0 in HOLD.
REQ-015 In HOLD, on an output transfer the held frame SHALL load into the output register in the same edge, io_out_valid stays 1, and the block returns to COLLECT with counter 0.
REQ-016 Output transfer with no replacement byte SHALL clear io_out_valid on the next edge.
REQ-017 io_out_bits and io_out_perr SHALL remain stable while io_out_valid = 1 and io_out_ready = 0.
REQ-018 io_in_ready SHALL be a registered function of state only, with no combinational path from io_out_ready.
REQ-019 Sustained throughput SHALL be one bit per cycle with no bubbles when io_out_ready is held at 1.

Reset
REQ-020 While reset = 1 on a clock edge: counter = 0, state = COLLECT, io_out_valid = 0, io_out_bits = 8'h00, io_out_perr = 0, io_in_ready = 1 from the next cycle.
REQ-021 Reset mid-frame or in HOLD SHALL discard all partial and held data; the first bit accepted after reset is bit 0 of a new frame.

Configuration
REQ-022 Macro PARITY_CHECK_EN: when defined, the frame is 9 bits (8 data bits followed by one even-parity bit); io_out_perr is loaded with the XOR of all 9 bits together with the byte, and the byte is still delivered.
REQ-023 When PARITY_CHECK_EN is undefined, the frame is 8 bits, io_out_perr is absent, and no parity logic is present.

Verification
REQ-024 Reset, LSB_FIRST=1, io_out_ready=1, serial bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> io_out_valid high exactly one cycle after the 8th bit with io_out_bits = 8'hA5.
REQ-025 LSB_FIRST=0, same bit sequence -> io_out_bits = 8'hA5 reversed = 8'hA5 for this palindrome; repeat with 1,1,0,0,0,0,0,0 -> 8'hC0.
REQ-026 io_out_ready=0, send two full bytes 8'h11 then 8'h22 -> io_in_ready = 0 after the second byte; io_out_bits holds 8'h11 stable; raise io_out_ready for one cycle -> io_out_bits = 8'h22, io_out_valid stays 1, io_in_ready = 1.
REQ-027 Assert reset after 5 bits of a frame -> io_out_valid = 0; the next 8 bits 8'h3C (LSB first) yield io_out_bits = 8'h3C.
REQ-028 With PARITY_CHECK_EN: frame 8'h03 with parity bit 0 -> io_out_perr = 0; frame 8'h03 with parity bit 1 -> io_out_perr = 1 and io_out_bits = 8'h03.
REQ-029 Back-to-back stream of 4 bytes with io_out_ready=1 and io_in_valid held high -> io_in_ready never drops and 4 output transfers occur in 32 (36 with parity) cycles.
